// File: rtl/pong_pkg.sv
// Pong geometry, derived centre positions and controller state encoding.
// Shared by the game controller and its paddle sub-module.
package pong_pkg;

  localparam logic [9:0] Y_CEIL    = 10'd40;
  localparam logic [9:0] Y_FLOOR   = 10'd440;
  localparam logic [9:0] X_LWALL   = 10'd0;
  localparam logic [9:0] X_RWALL   = 10'd639;
  localparam logic [9:0] X_PADDLEA = 10'd16;
  localparam logic [9:0] X_PADDLEB = 10'd616;
  localparam logic [9:0] PADDLE_W  = 10'd8;
  localparam logic [9:0] PADDLE_H  = 10'd64;
  localparam logic [9:0] BALL_W    = 10'd8;
  localparam logic [9:0] BALL_H    = 10'd8;

  // Centre of the 640x(ceiling..floor) court, minus half the object size
  localparam logic [9:0] X_CENTRE =
    (X_LWALL + X_RWALL + 10'd1) / 10'd2 - BALL_W / 10'd2;
  localparam logic [9:0] Y_CENTRE =
    (Y_CEIL + Y_FLOOR) / 10'd2 - BALL_H / 10'd2;
  localparam logic [9:0] Y_PADDLE_RST =
    (Y_CEIL + Y_FLOOR) / 10'd2 - PADDLE_H / 10'd2;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    POINT,
    GAMEOVER
  } state_e;

  function automatic logic [2:0] sat_inc(
    input logic [2:0] s,
    input logic [2:0] max
  );
    return (s >= max) ? max : s + 3'd1;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Controller <-> display/button bundle.
// master is the game controller side, slave the display/input side.
interface game_controller_if;
  logic       frame_tick;
  logic       start;
  logic       upA;
  logic       downA;
  logic       upB;
  logic       downB;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [9:0] y_paddleA;
  logic [9:0] y_paddleB;
  logic [2:0] scoreA;
  logic [2:0] scoreB;
  logic       lossA;
  logic       lossB;

  modport master (
    input  frame_tick, start,
    input  upA, downA, upB, downB,
    output x_ball, y_ball,
    output y_paddleA, y_paddleB,
    output scoreA, scoreB,
    output lossA, lossB
  );

  modport slave (
    output frame_tick, start,
    output upA, downA, upB, downB,
    input  x_ball, y_ball,
    input  y_paddleA, y_paddleB,
    input  scoreA, scoreB,
    input  lossA, lossB
  );
endinterface

// File: rtl/paddle_ctrl.sv
// One paddle: button-driven vertical move, clamped inside the court.
// Position only changes on cycles where en is high.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_SPEED = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y_paddle
);

  localparam logic [9:0] STEP  = 10'(PADDLE_SPEED);
  localparam logic [9:0] Y_MIN = Y_CEIL + 10'd1;
  localparam logic [9:0] Y_MAX = Y_FLOOR - PADDLE_H;

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (en) begin
      unique case (1'b1)
        up && !down:
          y_d = (y_q < Y_MIN + STEP) ? Y_MIN : y_q - STEP;
        down && !up:
          y_d = (y_q + STEP > Y_MAX) ? Y_MAX : y_q + STEP;
        default: y_d = y_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y_q <= Y_PADDLE_RST;
    else        y_q <= y_d;
  end

  assign y_paddle = y_q;

endmodule

// File: rtl/game_controller.sv
// Pong game controller: ball physics, scoring, serve and game-over flow.
// Every register advances only on frame_tick; outputs are the registers.
module game_controller
  import pong_pkg::*;
#(
  parameter int         BALL_SPEED   = 2,
  parameter int         PADDLE_SPEED = 4,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [2:0] WIN_SCORE    = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       upA,
  input  logic       downA,
  input  logic       upB,
  input  logic       downB,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] y_paddleA,
  output logic [9:0] y_paddleB,
  output logic [2:0] scoreA,
  output logic [2:0] scoreB,
  output logic       lossA,
  output logic       lossB
);

  localparam logic [9:0]  BS = 10'(BALL_SPEED);
  localparam logic [9:0]  X_HIT_A = X_PADDLEA + PADDLE_W + BS;
  localparam logic [9:0]  X_HIT_B = X_PADDLEB - BS;
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_left_q, dx_left_d;
  logic        dy_up_q, dy_up_d;
  logic [2:0]  score_a_q, score_a_d;
  logic [2:0]  score_b_q, score_b_d;
  logic        loss_a_q, loss_a_d;
  logic        loss_b_q, loss_b_d;
  logic [15:0] cnt_q, cnt_d;

  logic        pad_en;
  logic        at_a, at_b, ov_a, ov_b;
  logic [9:0]  y_step;
  logic        dy_up_step;
  logic [2:0]  inc_a, inc_b;

  assign pad_en = frame_tick && (state_q != GAMEOVER);

  paddle_ctrl #(.PADDLE_SPEED(PADDLE_SPEED)) u_paddle_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pad_en),
    .up       (upA),
    .down     (downA),
    .y_paddle (y_paddleA)
  );

  paddle_ctrl #(.PADDLE_SPEED(PADDLE_SPEED)) u_paddle_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pad_en),
    .up       (upB),
    .down     (downB),
    .y_paddle (y_paddleB)
  );

  // Hit tests see the paddle registers, i.e. before this frame's move
  assign ov_a = (y_q + BALL_H > y_paddleA) &&
                (y_q < y_paddleA + PADDLE_H);
  assign ov_b = (y_q + BALL_H > y_paddleB) &&
                (y_q < y_paddleB + PADDLE_H);
  assign at_a = dx_left_q && (x_q <= X_HIT_A);
  assign at_b = !dx_left_q && (x_q + BALL_W >= X_HIT_B);
  assign inc_a = sat_inc(score_a_q, WIN_SCORE);
  assign inc_b = sat_inc(score_b_q, WIN_SCORE);

  always_comb begin
    y_step     = dy_up_q ? y_q - BS : y_q + BS;
    dy_up_step = dy_up_q;
    if (dy_up_q && (y_q <= Y_CEIL + BS)) begin
      y_step     = Y_CEIL + 10'd1;
      dy_up_step = 1'b0;
    end else if (!dy_up_q &&
                 (y_q + BALL_H >= Y_FLOOR - BS)) begin
      y_step     = Y_FLOOR - BALL_H;
      dy_up_step = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_left_d = dx_left_q;
    dy_up_d   = dy_up_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    loss_a_d  = loss_a_q;
    loss_b_d  = loss_b_q;
    cnt_d     = cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          x_d       = X_CENTRE;
          y_d       = Y_CENTRE;
          score_a_d = '0;
          score_b_d = '0;
          loss_a_d  = 1'b0;
          loss_b_d  = 1'b0;
          cnt_d     = '0;
          if (start) begin
            state_d   = PLAY;
            x_d       = X_CENTRE + BS;
            y_d       = Y_CENTRE + BS;
            dx_left_d = 1'b0;
            dy_up_d   = 1'b0;
          end
        end
        PLAY: begin
          y_d     = y_step;
          dy_up_d = dy_up_step;
          unique case (1'b1)
            at_a && ov_a: begin
              x_d       = X_PADDLEA + PADDLE_W;
              dx_left_d = 1'b0;
            end
            at_b && ov_b: begin
              x_d       = X_PADDLEB - BALL_W;
              dx_left_d = 1'b1;
            end
            // A missed: next serve heads back toward A
            at_a && !ov_a: begin
              score_b_d = inc_b;
              dx_left_d = 1'b1;
              x_d       = X_CENTRE;
              y_d       = Y_CENTRE;
              cnt_d     = '0;
              loss_a_d  = (inc_b == WIN_SCORE);
              state_d   = (inc_b == WIN_SCORE) ?
                          GAMEOVER : POINT;
            end
            at_b && !ov_b: begin
              score_a_d = inc_a;
              dx_left_d = 1'b0;
              x_d       = X_CENTRE;
              y_d       = Y_CENTRE;
              cnt_d     = '0;
              loss_b_d  = (inc_a == WIN_SCORE);
              state_d   = (inc_a == WIN_SCORE) ?
                          GAMEOVER : POINT;
            end
            default:
              x_d = dx_left_q ? x_q - BS : x_q + BS;
          endcase
        end
        POINT: begin
          x_d = X_CENTRE;
          y_d = Y_CENTRE;
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
            dy_up_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        GAMEOVER: begin
          x_d = X_CENTRE;
          y_d = Y_CENTRE;
          if (start) begin
            state_d   = IDLE;
            score_a_d = '0;
            score_b_d = '0;
            loss_a_d  = 1'b0;
            loss_b_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= X_CENTRE;
      y_q       <= Y_CENTRE;
      dx_left_q <= 1'b0;
      dy_up_q   <= 1'b0;
      score_a_q <= '0;
      score_b_q <= '0;
      loss_a_q  <= 1'b0;
      loss_b_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_left_q <= dx_left_d;
      dy_up_q   <= dy_up_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      loss_a_q  <= loss_a_d;
      loss_b_q  <= loss_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x_ball = x_q;
  assign y_ball = y_q;
  assign scoreA = score_a_q;
  assign scoreB = score_b_q;
  assign lossA  = loss_a_q;
  assign lossB  = loss_b_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a frame-level Pong model in plain integers,
// driven with bot/random paddles and random frame_tick/start/reset.
module tb_game_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  game_controller_if gif();

  game_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (gif.frame_tick),
    .start      (gif.start),
    .upA        (gif.upA),
    .downA      (gif.downA),
    .upB        (gif.upB),
    .downB      (gif.downB),
    .x_ball     (gif.x_ball),
    .y_ball     (gif.y_ball),
    .y_paddleA  (gif.y_paddleA),
    .y_paddleB  (gif.y_paddleB),
    .scoreA     (gif.scoreA),
    .scoreB     (gif.scoreB),
    .lossA      (gif.lossA),
    .lossB      (gif.lossB)
  );

  int checks = 0;
  int errors = 0;

  localparam int PH_IDLE = 0, PH_PLAY = 1;
  localparam int PH_POINT = 2, PH_OVER = 3;
  localparam int M_NONE = 0, M_TRACK = 1, M_AVOID = 2;
  localparam int M_RAND = 3, M_MANUAL = 4;

  localparam logic [47:0] RST_V =
    {10'd316, 10'd236, 10'd208, 10'd208, 3'd0, 3'd0, 1'b0, 1'b0};

  // Game model: ball position/velocity in pixels, paddles, scores
  int m_x, m_y, m_vx, m_vy, m_pa, m_pb;
  int m_sa, m_sb, m_la, m_lb, m_phase, m_wait, m_serve_vx;
  int mode_a, mode_b;

  function automatic int clampp(input int v);
    if (v < 41) return 41;
    if (v > 376) return 376;
    return v;
  endfunction

  function automatic bit m_overlap(input int p);
    return (m_y + 8 > p) && (m_y < p + 64);
  endfunction

  function automatic logic [47:0] obs_v();
    return {gif.x_ball, gif.y_ball, gif.y_paddleA, gif.y_paddleB,
            gif.scoreA, gif.scoreB, gif.lossA, gif.lossB};
  endfunction

  function automatic logic [47:0] exp_v();
    return {10'(m_x), 10'(m_y), 10'(m_pa), 10'(m_pb),
            3'(m_sa), 3'(m_sb), 1'(m_la), 1'(m_lb)};
  endfunction

  task automatic model_reset();
    m_x = 316; m_y = 236; m_vx = 2; m_vy = 2;
    m_pa = 208; m_pb = 208;
    m_sa = 0; m_sb = 0; m_la = 0; m_lb = 0;
    m_phase = PH_IDLE; m_wait = 0; m_serve_vx = 2;
  endtask

  task automatic m_point(input bit b_scored);
    m_x = 316; m_y = 236; m_wait = 0;
    if (b_scored) begin
      m_sb++;
      m_serve_vx = -2;
      if (m_sb == 7) begin m_phase = PH_OVER; m_la = 1; end
      else m_phase = PH_POINT;
    end else begin
      m_sa++;
      m_serve_vx = 2;
      if (m_sa == 7) begin m_phase = PH_OVER; m_lb = 1; end
      else m_phase = PH_POINT;
    end
  endtask

  task automatic model_frame();
    int pa0, pb0, ny, nvy;
    pa0 = m_pa;
    pb0 = m_pb;
    if (m_phase != PH_OVER) begin
      m_pa = clampp(m_pa + 4 * (int'(gif.downA) - int'(gif.upA)));
      m_pb = clampp(m_pb + 4 * (int'(gif.downB) - int'(gif.upB)));
    end
    case (m_phase)
      PH_IDLE: begin
        m_x = 316; m_y = 236;
        m_sa = 0; m_sb = 0; m_la = 0; m_lb = 0;
        if (gif.start) begin
          m_phase = PH_PLAY;
          m_vx = 2; m_vy = 2;
          m_x = 316 + m_vx; m_y = 236 + m_vy;
        end
      end
      PH_PLAY: begin
        ny = m_y + m_vy;
        nvy = m_vy;
        if (m_vy < 0 && m_y <= 42) begin ny = 41; nvy = 2; end
        else if (m_vy > 0 && m_y + 8 >= 438) begin
          ny = 432; nvy = -2;
        end
        if (m_vx < 0 && m_x <= 26) begin
          if (m_y + 8 > pa0 && m_y < pa0 + 64) begin
            m_x = 24; m_vx = 2; m_y = ny; m_vy = nvy;
          end else m_point(1'b1);
        end else if (m_vx > 0 && m_x + 8 >= 614) begin
          if (m_y + 8 > pb0 && m_y < pb0 + 64) begin
            m_x = 608; m_vx = -2; m_y = ny; m_vy = nvy;
          end else m_point(1'b0);
        end else begin
          m_x = m_x + m_vx; m_y = ny; m_vy = nvy;
        end
      end
      PH_POINT: begin
        m_wait++;
        if (m_wait == 60) begin
          m_phase = PH_PLAY; m_wait = 0;
          m_vx = m_serve_vx; m_vy = 2;
        end
      end
      default: begin
        if (gif.start) begin
          m_phase = PH_IDLE;
          m_sa = 0; m_sb = 0; m_la = 0; m_lb = 0;
        end
      end
    endcase
  endtask

  task automatic drive_pad(input int mode, input int p,
                           output logic up, output logic dn);
    case (mode)
      M_TRACK: begin
        up = (p + 32 > m_y + 7);
        dn = (p + 32 < m_y + 1);
      end
      M_AVOID: begin
        up = (m_y >= 240);
        dn = (m_y < 240);
      end
      M_RAND: begin
        up = 1'($urandom_range(0, 1));
        dn = 1'($urandom_range(0, 1));
      end
      default: begin up = 1'b0; dn = 1'b0; end
    endcase
  endtask

  task automatic cyc(input bit tick);
    logic u, d;
    if (mode_a != M_MANUAL) begin
      drive_pad(mode_a, m_pa, u, d);
      gif.upA = u; gif.downA = d;
    end
    if (mode_b != M_MANUAL) begin
      drive_pad(mode_b, m_pb, u, d);
      gif.upB = u; gif.downB = d;
    end
    gif.frame_tick = tick;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (tick) model_frame();
    @(negedge clk);
  endtask

  task automatic do_reset();
    gif.start = 1'b0;
    rst_n = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic serve();
    gif.start = 1'b1;
    cyc(1'b1);
    gif.start = 1'b0;
  endtask

  task automatic test_reset();
    mode_a = M_RAND; mode_b = M_RAND;
    rst_n = 1'b0;
    gif.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)));
      checks++;
      if (obs_v() !== RST_V) begin
        errors++;
        $display("FAIL reset got %h want %h", obs_v(), RST_V);
      end
    end
    gif.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    logic [47:0] want;
    mode_a = M_NONE; mode_b = M_NONE;
    do_reset();
    gif.start = 1'b1;
    cyc(1'b0);
    checks++;
    if (obs_v() !== RST_V) begin
      errors++;
      $display("FAIL no_tick_hold got %h want %h", obs_v(), RST_V);
    end
    cyc(1'b1);
    gif.start = 1'b0;
    want = {10'd318, 10'd238, 10'd208, 10'd208, 3'd0, 3'd0, 2'b00};
    checks++;
    if (obs_v() !== want) begin
      errors++;
      $display("FAIL start_play got %h want %h", obs_v(), want);
    end
  endtask

  task automatic test_ceiling();
    bit found;
    mode_a = M_TRACK; mode_b = M_TRACK;
    do_reset();
    serve();
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_phase == PH_PLAY && m_vy < 0 && m_y == 42) found = 1'b1;
      else begin
        cyc(1'b1);
        checks++;
        if (obs_v() !== exp_v()) begin
          errors++;
          $display("FAIL ceil_run got %h want %h", obs_v(), exp_v());
        end
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL ceil_wait got timeout want y=42 up");
    end else begin
      cyc(1'b1);
      checks++;
      if (gif.y_ball !== 10'd41) begin
        errors++;
        $display("FAIL ceil_bounce got %0d want 41", gif.y_ball);
      end
      cyc(1'b1);
      checks++;
      if (gif.y_ball !== 10'd43) begin
        errors++;
        $display("FAIL ceil_dy got %0d want 43", gif.y_ball);
      end
    end
  endtask

  task automatic test_paddle_hit();
    bit found;
    int sa0, sb0;
    mode_a = M_TRACK; mode_b = M_TRACK;
    do_reset();
    serve();
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_phase == PH_PLAY && m_vx < 0 && m_x == 26 &&
          m_overlap(m_pa)) found = 1'b1;
      else begin
        cyc(1'b1);
        checks++;
        if (obs_v() !== exp_v()) begin
          errors++;
          $display("FAIL hit_run got %h want %h", obs_v(), exp_v());
        end
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL hit_wait got timeout want x=26 overlap");
    end else begin
      sa0 = m_sa; sb0 = m_sb;
      cyc(1'b1);
      checks++;
      if ({gif.x_ball, gif.scoreA, gif.scoreB} !==
          {10'd24, 3'(sa0), 3'(sb0)}) begin
        errors++;
        $display("FAIL hit_a got x=%0d sa=%0d sb=%0d want x=24 sa=%0d sb=%0d",
                 gif.x_ball, gif.scoreA, gif.scoreB, sa0, sb0);
      end
      cyc(1'b1);
      checks++;
      if (gif.x_ball !== 10'd26) begin
        errors++;
        $display("FAIL hit_dx got %0d want 26", gif.x_ball);
      end
    end
  endtask

  task automatic test_miss_serve();
    bit found;
    int sb0;
    mode_a = M_AVOID; mode_b = M_TRACK;
    do_reset();
    serve();
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_phase == PH_PLAY && m_vx < 0 && m_x == 26 &&
          !m_overlap(m_pa)) found = 1'b1;
      else cyc(1'b1);
    end
    if (!found) begin
      errors++;
      $display("FAIL miss_wait got timeout want x=26 miss");
      return;
    end
    sb0 = m_sb;
    cyc(1'b1);
    checks++;
    if ({gif.scoreB, gif.x_ball, gif.y_ball} !==
        {3'(sb0 + 1), 10'd316, 10'd236}) begin
      errors++;
      $display("FAIL miss_a got sb=%0d x=%0d y=%0d want sb=%0d x=316 y=236",
               gif.scoreB, gif.x_ball, gif.y_ball, sb0 + 1);
    end
    for (int i = 1; i <= 60; i++) begin
      cyc(1'b1);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL serve_hold got %h want %h", obs_v(), exp_v());
      end
    end
    checks++;
    if ({gif.x_ball, gif.y_ball} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL serve_centre got %0d,%0d want 316,236",
               gif.x_ball, gif.y_ball);
    end
    cyc(1'b1);
    checks++;
    if ({gif.x_ball, gif.y_ball} !== {10'd314, 10'd238}) begin
      errors++;
      $display("FAIL serve_dir got %0d,%0d want 314,238",
               gif.x_ball, gif.y_ball);
    end
  endtask

  task automatic test_game_over();
    bit found;
    int pa0, pb0;
    logic [47:0] want;
    mode_a = M_AVOID; mode_b = M_TRACK;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (m_phase == PH_OVER) found = 1'b1;
      else begin
        cyc(1'b1);
        checks++;
        if (obs_v() !== exp_v()) begin
          errors++;
          $display("FAIL game_run got %h want %h", obs_v(), exp_v());
        end
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL over_wait got timeout want GAMEOVER");
      return;
    end
    checks++;
    if ({gif.scoreB, gif.lossA, gif.lossB} !== {3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL over_flags got sb=%0d la=%0b lb=%0b want 7 1 0",
               gif.scoreB, gif.lossA, gif.lossB);
    end
    pa0 = m_pa; pb0 = m_pb;
    mode_a = M_RAND; mode_b = M_RAND;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1);
      checks++;
      if ({gif.y_paddleA, gif.y_paddleB, gif.scoreB, gif.lossA} !==
          {10'(pa0), 10'(pb0), 3'd7, 1'b1}) begin
        errors++;
        $display("FAIL over_frozen got %0d,%0d sb=%0d want %0d,%0d sb=7",
                 gif.y_paddleA, gif.y_paddleB, gif.scoreB, pa0, pb0);
      end
    end
    gif.start = 1'b1;
    cyc(1'b1);
    gif.start = 1'b0;
    want = {10'd316, 10'd236, 10'(pa0), 10'(pb0), 3'd0, 3'd0, 2'b00};
    checks++;
    if (obs_v() !== want) begin
      errors++;
      $display("FAIL restart got %h want %h", obs_v(), want);
    end
  endtask

  task automatic test_paddles();
    mode_a = M_MANUAL; mode_b = M_MANUAL;
    do_reset();
    gif.upA = 1'b1; gif.downA = 1'b1;
    gif.upB = 1'b0; gif.downB = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1);
    checks++;
    if (gif.y_paddleA !== 10'd208) begin
      errors++;
      $display("FAIL pad_both got %0d want 208", gif.y_paddleA);
    end
    gif.downA = 1'b0;
    for (int i = 0; i < 50; i++) cyc(1'b1);
    checks++;
    if (gif.y_paddleA !== 10'd41) begin
      errors++;
      $display("FAIL pad_top got %0d want 41", gif.y_paddleA);
    end
    gif.upA = 1'b0; gif.downB = 1'b1;
    for (int i = 0; i < 50; i++) cyc(1'b1);
    checks++;
    if ({gif.y_paddleA, gif.y_paddleB} !== {10'd41, 10'd376}) begin
      errors++;
      $display("FAIL pad_bottom got %0d,%0d want 41,376",
               gif.y_paddleA, gif.y_paddleB);
    end
    gif.downB = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    mode_a = M_RAND; mode_b = M_RAND;
    do_reset();
    serve();
    for (int i = 0; i < 40; i++) cyc(1'b1);
    rst_n = 1'b0;
    cyc(1'b1);
    rst_n = 1'b1;
    checks++;
    if (obs_v() !== RST_V) begin
      errors++;
      $display("FAIL rst_play got %h want %h", obs_v(), RST_V);
    end
    mode_a = M_NONE; mode_b = M_NONE;
    serve();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (m_phase == PH_POINT && m_wait > 3) found = 1'b1;
      else cyc(1'b1);
    end
    if (!found) begin
      errors++;
      $display("FAIL point_wait got timeout want POINT");
    end
    rst_n = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    checks++;
    if (obs_v() !== RST_V) begin
      errors++;
      $display("FAIL rst_point got %h want %h", obs_v(), RST_V);
    end
    serve();
    checks++;
    if ({gif.x_ball, gif.y_ball} !== {10'd318, 10'd238}) begin
      errors++;
      $display("FAIL rst_dir got %0d,%0d want 318,238",
               gif.x_ball, gif.y_ball);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      if (i % 1000 == 0) begin
        mode_a = $urandom_range(M_TRACK, M_RAND);
        mode_b = $urandom_range(M_TRACK, M_RAND);
      end
      gif.start = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      cyc($urandom_range(0, 2) != 0);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL random got %h want %h", obs_v(), exp_v());
      end
    end
    rst_n = 1'b1;
    gif.start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    gif.frame_tick = 1'b0;
    gif.start = 1'b0;
    gif.upA = 1'b0; gif.downA = 1'b0;
    gif.upB = 1'b0; gif.downB = 1'b0;
    mode_a = M_NONE; mode_b = M_NONE;
    model_reset();
    @(negedge clk);
    test_reset();
    test_start();
    test_ceiling();
    test_paddle_hit();
    test_miss_serve();
    test_game_over();
    test_paddles();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter BALL_SPEED, default 2, meaning ball step in pixels per frame on each axis.
REQ-002 The block SHALL have parameter PADDLE_SPEED, default 4, meaning paddle step in pixels per frame.
REQ-003 The block SHALL have parameter SERVE_FRAMES, default 60, meaning frames the ball is held centred after a point.
REQ-004 The block SHALL have parameter WIN_SCORE, default 7, meaning the score that ends the game (3-bit).
REQ-005 The block SHALL have these ports: clk input 1 (system clock); rst_n input 1 (reset, synchronous, active-low).
REQ-006 The block SHALL have these ports: frame_tick input 1 (one-cycle pulse per video frame); start input 1 (level, start/restart request).
REQ-007 The block SHALL have these ports: upA, downA, upB, downB input 1 each (level paddle buttons).
REQ-008 The block SHALL have these ports: x_ball, y_ball output 10 (ball top-left); y_paddleA, y_paddleB output 10 (paddle top).
REQ-009 The block SHALL have these ports: scoreA, scoreB output 3; lossA, lossB output 1 (player lost game).
REQ-010 Clocking SHALL be one clock, clk; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-011 Geometry SHALL use these package constants: Y_CEIL 40, Y_FLOOR 440, X_LWALL 0, X_RWALL 639, X_PADDLEA 16, X_PADDLEB 616, PADDLE_W 8, PADDLE_H 64, BALL_W 8, BALL_H 8.
REQ-012 All state SHALL update only in cycles where frame_tick=1; outputs SHALL be registered, valid one cycle after frame_tick, and held otherwise.
REQ-013 The FSM SHALL have states IDLE, PLAY, POINT, GAMEOVER.
REQ-014 IDLE SHALL behave as follows: ball centred (316,236), scores 0; on frame_tick with start=1 -> PLAY with dx=+1, dy=+1.
REQ-015 PLAY SHALL add dx*BALL_SPEED to x_ball and dy*BALL_SPEED to y_ball each frame; these are 10-bit unsigned values, and the collision rules SHALL prevent underflow.
REQ-016 Ceiling: when dy=-1 and y_ball <= Y_CEIL+BALL_SPEED, then y_ball <= Y_CEIL+1 and dy <= +1.
REQ-017 Floor: when dy=+1 and y_ball+BALL_H >= Y_FLOOR-BALL_SPEED, then y_ball <= Y_FLOOR-BALL_H and dy <= -1.
REQ-018 Paddle A hit: when dx=-1, x_ball <= X_PADDLEA+PADDLE_W+BALL_SPEED, y_ball+BALL_H > y_paddleA and y_ball < y_paddleA+PADDLE_H, then x_ball <= X_PADDLEA+PADDLE_W and dx <= +1; paddle B hit SHALL be the mirror case.
REQ-019 Miss: when dx=-1, x_ball <= X_PADDLEA+PADDLE_W+BALL_SPEED and no overlap, then scoreB increments -> POINT; the mirror case increments scoreA.
REQ-020 Simultaneous events: a vertical bounce and a paddle hit or miss in the same frame SHALL both be applied.
REQ-021 POINT SHALL hold the ball centred and count frame_ticks from 0; at count SERVE_FRAMES-1 -> PLAY with dx toward the player who just scored against, and dy=+1.
REQ-022 When an increment makes a score equal WIN_SCORE, the FSM SHALL go -> GAMEOVER instead of POINT; lossA=1 if scoreB reached WIN_SCORE, else lossB=1.
REQ-023 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-024 GAMEOVER SHALL hold the ball centred with scores and loss flags frozen; on frame_tick with start=1 -> IDLE, clearing scores and loss flags.
REQ-025 Paddles SHALL move in IDLE, PLAY and POINT, and be frozen in GAMEOVER.
REQ-026 Paddle movement: up-only moves the paddle up by PADDLE_SPEED, down-only moves it down; both or neither pressed means no move.
REQ-027 Paddle position SHALL be clamped to [Y_CEIL+1, Y_FLOOR-PADDLE_H].
REQ-028 A paddle hit test SHALL use the paddle position before that frame's paddle update.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL enter IDLE regardless of frame_tick and state, including mid-PLAY or mid-POINT.
REQ-030 Reset values SHALL be: x_ball=316, y_ball=236, y_paddleA=y_paddleB=208, scores 0, lossA=lossB=0, dx=+1, dy=+1, serve counter 0.

Structure
REQ-031 Package pong_pkg SHALL hold the geometry constants, the centre positions and the FSM state enum.
REQ-032 Paddle movement and clamping SHALL be one sub-module, paddle_ctrl, instantiated twice (A and B).
REQ-033 Outputs SHALL connect directly to the display controller's ball, paddle, score and loss inputs.

Verification
REQ-034 Reset release, then frame_tick with start=1 -> next cycle state PLAY and ball at (318,238).
REQ-035 Ball at y=42 moving up, frame_tick -> y_ball=41, dy=+1.
REQ-036 Ball at x=26 moving left with paddle A at y=208 and ball y=230, frame_tick -> x_ball=24, dx=+1, scores unchanged.
REQ-037 Same as REQ-036 but paddle A at y=100 -> scoreB increments, state POINT; after 60 frame_ticks -> PLAY with dx=-1.
REQ-038 Bench drives scoreB to 6, then a miss by A -> scoreB=7, lossA=1, GAMEOVER; start -> IDLE with scores 0.
REQ-039 upA and downA both held -> y_paddleA unchanged; upA held from 208 -> stops at 41; rst_n=0 mid-PLAY -> all REQ-030 values on the next cycle.
